// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-access stage between the single-cycle datapath and a req/gnt/rvalid
//   data memory. It takes one load or store per request and issues word-aligned
//   memory transactions with byte enables. Load data comes back sign- or
//   zero-extended. While the access is in flight, stall holds the datapath.
//
//   Build option: define LSU_MISALIGNED_EN to split accesses that cross a word
//   boundary into two word transactions. If it is left undefined, such
//   accesses complete immediately with access_err and make no memory traffic.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   req_valid/req_store      access request, 1=store 0=load
//   req_funct3               RISC-V width/sign code
//   req_addr, req_wdata      byte address, right-aligned store data
//   stall                    datapath must hold this cycle
//   resp_valid/resp_rdata    completion pulse, extended load data (0 for stores/errors)
//   access_err               with resp_valid: illegal funct3 or unsupported misalignment
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata   memory request channel
//   mem_gnt, mem_rvalid, mem_rdata             memory grant and read return
module load_store_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        access_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_REQ2, S_WAIT2, S_DONE
    } state_t;

    state_t state, state_nx;

    logic        store_q, split_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [7:0]  mask_q;
    logic [63:0] wdata_q;
    logic [31:0] word0_q, word1_q;

    logic        in_illegal, in_cross, in_err, in_split;
    logic [7:0]  in_base, in_mask;
    logic [63:0] in_wdata;
    logic [63:0] joined;
    logic [31:0] shifted;

    // Decode of the incoming request (only consumed in IDLE)
    always_comb begin
        in_illegal = req_store ? (req_funct3 >= 3'd3)
                               : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
        in_cross   = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'd3)) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'd0));
        case (req_funct3[1:0])
            2'b00:   in_base = 8'h01;
            2'b01:   in_base = 8'h03;
            default: in_base = 8'h0F;
        endcase
        // Lane mask and data span two words; the upper half feeds the second transaction
        in_mask  = in_base << req_addr[1:0];
        in_wdata = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
`ifdef LSU_MISALIGNED_EN
        in_err   = in_illegal;
        in_split = in_cross & ~in_illegal;
`else
        in_err   = in_illegal | in_cross;
        in_split = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (req_valid)  state_nx = in_err ? S_DONE : S_REQ;
            S_REQ:   if (mem_gnt)    state_nx = store_q ? (split_q ? S_REQ2 : S_DONE) : S_WAIT;
            S_WAIT:  if (mem_rvalid) state_nx = split_q ? S_REQ2 : S_DONE;
            S_REQ2:  if (mem_gnt)    state_nx = store_q ? S_DONE : S_WAIT2;
            S_WAIT2: if (mem_rvalid) state_nx = S_DONE;
            S_DONE:                  state_nx = S_IDLE;
            default:                 state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store_q <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                store_q <= req_store;
                split_q <= in_split;
                err_q   <= in_err;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                addr_q  <= {req_addr[31:2], 2'b00};
                mask_q  <= in_mask;
                wdata_q <= req_store ? in_wdata : '0;
                word0_q <= '0;
                word1_q <= '0;
            end
            if (state == S_WAIT  && mem_rvalid) word0_q <= mem_rdata;
            if (state == S_WAIT2 && mem_rvalid) word1_q <= mem_rdata;
        end
    end

    // Load alignment: shift the two-word window down to the addressed byte
    always_comb begin
        joined  = {word1_q, word0_q} >> {off_q, 3'b000};
        shifted = joined[31:0];
    end

    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        access_err = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        case (state)
            // reset_n gate keeps stall low while reset is asserted
            S_IDLE: stall = req_valid & reset_n;
            S_REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = addr_q;
                mem_be    = mask_q[3:0];
                mem_wdata = wdata_q[31:0];
            end
            S_REQ2: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = addr_q + 32'd4;
                mem_be    = mask_q[7:4];
                mem_wdata = wdata_q[63:32];
            end
            S_WAIT, S_WAIT2: stall = 1'b1;
            S_DONE: begin
                resp_valid = 1'b1;
                access_err = err_q;
                if (!store_q && !err_q) begin
                    case (f3_q)
                        3'b000:  resp_rdata = {{24{shifted[7]}}, shifted[7:0]};
                        3'b001:  resp_rdata = {{16{shifted[15]}}, shifted[15:0]};
                        3'b100:  resp_rdata = {24'b0, shifted[7:0]};
                        3'b101:  resp_rdata = {16'b0, shifted[15:0]};
                        default: resp_rdata = shifted;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, access_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .access_err (access_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rexp_t;

    mexp_t mq[$];
    rexp_t rq[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_mem(input logic [31:0] a, input logic [3:0] be, input logic we,
                           input logic [31:0] wd);
        mexp_t m;
        m.addr = a; m.be = be; m.we = we; m.wdata = wd;
        mq.push_back(m);
    endtask

    task automatic exp_resp(input logic [31:0] rd, input logic err, input int cyc);
        rexp_t r;
        r.rdata = rd; r.err = err; r.cyc = cyc;
        rq.push_back(r);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},      32'(stall),      32'd0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata,      32'd0);
        chk({tag, "_access_err"}, 32'(access_err), 32'd0);
        chk({tag, "_mem_req"},    32'(mem_req),    32'd0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
        chk({tag, "_mem_addr"},   mem_addr,        32'd0);
        chk({tag, "_mem_be"},     32'(mem_be),     32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
    endtask

    // Issue one access and act as the memory: grant after gdly waiting cycles,
    // return read data rdly cycles after the grant. Stray gnt/rvalid are driven
    // in states where they must be ignored.
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input int gdly, input int rdly,
                       input logic [31:0] w0, input logic [31:0] w1);
        int    cyc, wcnt, rcnt, ridx;
        logic  pend, done;
        mexp_t m;
        rexp_t r;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1 chk("stall_c0", 32'(stall), 32'd1);
        cyc = 0; wcnt = 0; rcnt = 0; ridx = 0; pend = 1'b0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
            if (resp_valid) begin
                done = 1'b1;
                r = rq.pop_front();
                chk("resp_rdata", resp_rdata, r.rdata);
                chk("access_err", 32'(access_err), 32'(r.err));
                chk("resp_cycle", 32'(cyc), 32'(r.cyc));
                chk("stall_done", 32'(stall), 32'd0);
                chk("mem_req_done", 32'(mem_req), 32'd0);
                req_valid = 1'b0;
            end else begin
                chk("stall_busy", 32'(stall), 32'd1);
                if (mem_req) begin
                    if (mq.size() == 0) begin
                        chk("spurious_mem_req", 32'(mem_req), 32'd0);
                    end else begin
                        m = mq[0];
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_be", 32'(mem_be), 32'(m.be));
                        chk("mem_we", 32'(mem_we), 32'(m.we));
                        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                        if (wcnt == gdly) begin
                            mem_gnt = 1'b1;
                            m = mq.pop_front();
                            wcnt = 0;
                            pend = !st;
                        end else begin
                            wcnt++;
                            mem_rvalid = 1'b1;
                        end
                    end
                end else if (pend) begin
                    if (rcnt == rdly) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = (ridx == 0) ? w0 : w1;
                        ridx++;
                        rcnt = 0;
                        pend = 1'b0;
                    end else begin
                        rcnt++;
                        mem_gnt = 1'b1;
                    end
                end
            end
        end
        chk("resp_seen", 32'(done), 32'd1);
        mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
        chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // LW aligned
        exp_mem(32'h100, 4'b1111, 1'b0, 32'h0);
        exp_resp(32'h8899AABB, 1'b0, 3);
        run(1'b0, 3'b010, 32'h100, 32'h12345678, 0, 0, 32'h8899AABB, 32'h0);

        // LB / LBU at offset 3
        exp_mem(32'h100, 4'b1000, 1'b0, 32'h0);
        exp_resp(32'hFFFFFF80, 1'b0, 3);
        run(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80000000, 32'h0);
        exp_mem(32'h100, 4'b1000, 1'b0, 32'h0);
        exp_resp(32'h00000080, 1'b0, 3);
        run(1'b0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80000000, 32'h0);

        // LH / LHU at offset 2
        exp_mem(32'h100, 4'b1100, 1'b0, 32'h0);
        exp_resp(32'hFFFF8001, 1'b0, 3);
        run(1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80017F00, 32'h0);
        exp_mem(32'h100, 4'b1100, 1'b0, 32'h0);
        exp_resp(32'h00008001, 1'b0, 3);
        run(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, 32'h80017F00, 32'h0);

        // SH offset 2
        exp_mem(32'h200, 4'b1100, 1'b1, 32'hABCD0000);
        exp_resp(32'h0, 1'b0, 2);
        run(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'h0, 32'h0);

        // SB at the top of the address space
        exp_mem(32'hFFFFFFFC, 4'b1000, 1'b1, 32'h5A000000);
        exp_resp(32'h0, 1'b0, 2);
        run(1'b1, 3'b000, 32'hFFFFFFFF, 32'h1234565A, 0, 0, 32'h0, 32'h0);

        // Illegal funct3: load 011, store 100
        exp_resp(32'h0, 1'b1, 1);
        run(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0);
        exp_resp(32'h0, 1'b1, 1);
        run(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h0);

        // Boundary-crossing accesses
`ifdef LSU_MISALIGNED_EN
        exp_mem(32'h300, 4'b1110, 1'b1, 32'hBBCCDD00);
        exp_mem(32'h304, 4'b0001, 1'b1, 32'h000000AA);
        exp_resp(32'h0, 1'b0, 3);
        run(1'b1, 3'b010, 32'h301, 32'hAABBCCDD, 0, 0, 32'h0, 32'h0);
        exp_mem(32'h3FC, 4'b1000, 1'b0, 32'h0);
        exp_mem(32'h400, 4'b0001, 1'b0, 32'h0);
        exp_resp(32'hFFFF8811, 1'b0, 5);
        run(1'b0, 3'b001, 32'h3FF, 32'h0, 0, 0, 32'h11223344, 32'h55667788);
        exp_mem(32'hFFFFFFFC, 4'b1000, 1'b1, 32'hEF000000);
        exp_mem(32'h00000000, 4'b0001, 1'b1, 32'h00CAFEBE);
        exp_resp(32'h0, 1'b0, 3);
        run(1'b1, 3'b001, 32'hFFFFFFFF, 32'hCAFEBEEF, 0, 0, 32'h0, 32'h0);
`else
        exp_resp(32'h0, 1'b1, 1);
        run(1'b1, 3'b010, 32'h301, 32'hAABBCCDD, 0, 0, 32'h0, 32'h0);
        exp_resp(32'h0, 1'b1, 1);
        run(1'b0, 3'b001, 32'h3FF, 32'h0, 0, 0, 32'h11223344, 32'h55667788);
        exp_resp(32'h0, 1'b1, 1);
        run(1'b1, 3'b001, 32'hFFFFFFFF, 32'hCAFEBEEF, 0, 0, 32'h0, 32'h0);
`endif

        // Delayed grant (3) and read data (2)
        exp_mem(32'h40, 4'b1111, 1'b0, 32'h0);
        exp_resp(32'h0BADF00D, 1'b0, 8);
        run(1'b0, 3'b010, 32'h40, 32'h0, 3, 2, 32'h0BADF00D, 32'h0);

        // Reset while waiting for read data
        @(negedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h500;
        @(posedge clk);
        @(negedge clk);
        chk("rst_seq_mem_req", 32'(mem_req), 32'd1);
        chk("rst_seq_mem_addr", mem_addr, 32'h500);
        mem_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rst_seq_wait_stall", 32'(stall), 32'd1);
        reset_n = 1'b0; req_valid = 1'b0;
        #1 chk_all_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h13572468;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_reset_resp_valid", 32'(resp_valid), 32'd0);
            chk("post_reset_stall", 32'(stall), 32'd0);
        end
        mem_rvalid = 1'b0;

        // Normal access after reset recovery
        exp_mem(32'h600, 4'b1111, 1'b0, 32'h0);
        exp_resp(32'hCAFEF00D, 1'b0, 3);
        run(1'b0, 3'b010, 32'h600, 32'h0, 0, 0, 32'hCAFEF00D, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the single-cycle datapath and a handshaked data memory. It accepts one load or store per request using the ALU address, rs2 data and funct3, and drives a req/gnt/rvalid memory bus with word-aligned addresses and byte enables. Load data returns sign- or zero-extended, and a stall output freezes the datapath until the access completes. Misaligned accesses are split into two word transactions when the feature is compiled in.

## Interface
- Clocking: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- No parameters; all data/address paths are 32 bits.
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  async active-low reset
- `req_valid`  in  1  access requested; held stable with all req_* while `stall`=1
- `req_store`  in  1  1=store, 0=load
- `req_funct3`  in  3  RISC-V width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `req_addr`  in  32  byte address (ALU result)
- `req_wdata`  in  32  store data (rs2), right-aligned
- `stall`  out  1  datapath must hold PC/request this cycle
- `resp_valid`  out  1  one-cycle pulse: access complete
- `resp_rdata`  out  32  extended load data; 0 for stores/errors
- `access_err`  out  1  with `resp_valid`: illegal funct3 or unsupported misalignment
- `mem_req`  out  1  memory request
- `mem_we`  out  1  write request
- `mem_addr`  out  32  word address, bits [1:0]=0
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-aligned write data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid (≥1 cycle after gnt)
- `mem_rdata`  in  32  read word

## Operation
- States: IDLE, REQ, WAIT, REQ2, WAIT2, DONE.
- IDLE: on `req_valid`, latch request, offset=addr[1:0]. Illegal funct3 (load 011/110/111; store ≥011) or misaligned-unsupported -> DONE with `access_err`, no memory traffic; else -> REQ.
- Misaligned = half at offset 3, word at offset≠0 (crosses word boundary).
- REQ: `mem_req`=1, addr=req_addr&~3; hold all mem_* stable until `mem_gnt`. On gnt: store -> REQ2 if split else DONE; load -> WAIT.
- WAIT: on `mem_rvalid` capture word0; -> REQ2 if split else DONE.
- REQ2/WAIT2: same for address+4 (wraps mod 2^32); capture word1; -> DONE.
- DONE: `resp_valid`=1, `stall`=0; -> IDLE.
- Byte lanes: mask8 = {0001,0011,1111}[size] << offset (8 bits); first word be=mask8[3:0], second be=mask8[7:4]. Write data: ({32'b0,wdata} << 8·offset), low/high halves per word.
- Load: ({word1,word0} >> 8·offset)[31:0], then LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
- `stall` = `req_valid` in IDLE, or state ∈ {REQ,WAIT,REQ2,WAIT2}; 0 in DONE.
- `mem_rvalid` outside WAIT/WAIT2 ignored; `mem_gnt` outside REQ/REQ2 ignored.

## Timing
- Reset: state IDLE; all outputs 0; latched request/data cleared. Reset mid-access abandons it, no `resp_valid`.
- Aligned load, gnt immediate, rvalid next cycle: valid seen C0, REQ C1, WAIT C2, `resp_valid` C3.
- Aligned store, gnt immediate: `resp_valid` C2. Error: `resp_valid` C1.
- Each gnt/rvalid stall adds one cycle per cycle of delay; no timeout.
- New request accepted only in IDLE; cycle after DONE is IDLE.

## Configuration
- `LSU_MISALIGNED_EN` defined: boundary-crossing accesses split into two transactions (REQ2/WAIT2 reachable).
- Undefined: such accesses finish in DONE with `access_err`=1, no memory traffic; REQ2/WAIT2 unreachable.

## Test plan
- LW addr 0x100, mem returns 0x8899AABB -> mem_addr 0x100, be 1111, resp_rdata 0x8899AABB at C3.
- LB addr 0x103 / LBU same, word 0x80000000 -> 0xFFFFFF80 / 0x00000080.
- SH addr 0x202 wdata 0x1234ABCD -> mem_addr 0x200, be 1100, mem_wdata 0xABCD0000, resp C2.
- SW addr 0x301 wdata 0xAABBCCDD, macro on -> be 1110 @0x300 data 0xBBCCDD00, then be 0001 @0x304 data 0x000000AA; macro off -> access_err, no mem_req.
- gnt delayed 3 cycles, rvalid delayed 2 -> mem_* stable throughout, stall held, resp_valid at C8.
- reset_n low while WAIT -> all outputs 0 immediately, IDLE, later rvalid ignored.
